lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
Clocked, parametrised load/store unit that replaces the combinational single-cycle data memory path.
- Accepts one RV load/store request per transaction from the execute stage over a valid/ready handshake.
- Drives an aligned, byte-strobed request to a variable-latency memory port.
- Returns sign- or zero-extended load data, or a store acknowledge, over a second valid/ready handshake.
- Misaligned accesses and unsupported sizes are trapped locally (error response) and never reach memory.

Parameters:
XLEN, 32, data width in bits; legal values 32 or 64.
ADDR_W, 32, byte address width.
STRB_W, XLEN/8, derived byte-lane count; not overridable.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request offered by execute stage
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV funct3 size/sign code
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, right-justified
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned or illegal size
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_we  out  1  write enable
mem_addr  out  ADDR_W  req_addr with low log2(STRB_W) bits cleared
mem_wdata  out  XLEN  store data shifted left by offset*8
mem_wstrb  out  STRB_W  byte-lane mask (size mask << offset); 0 on reads
mem_rsp_valid  in  1  read data valid or write acknowledge
mem_rdata  in  XLEN  full aligned word from memory

Behaviour:
- Reset: state IDLE, all registered outputs 0 (req_ready, rsp_valid, rsp_err, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, rsp_rdata).
- Reset asserted mid-transaction aborts it. A later mem_rsp_valid arriving in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: register op, funct3, address, offset.
  - Size decode: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. XLEN=64 adds 011 ld and 110 lwu.
  - Stores use only 000/001/010, plus 011 when XLEN=64.
  - Any other code is illegal.
  - Illegal code, or address not aligned to the access size → RESP with rsp_err=1, rsp_rdata=0, no memory access.
  - Otherwise → REQ.
- REQ:
  - mem_req_valid=1; mem_addr, mem_we, mem_wdata and mem_wstrb are held stable until mem_req_ready.
  - On mem_req_ready → WAIT; mem_req_valid drops the next cycle.
- WAIT:
  - On mem_rsp_valid, load data = mem_rdata >> (offset*8), truncated to the access size, then sign- or zero-extended to XLEN; store gives 0.
  - Registered into rsp_rdata, rsp_err=0 → RESP.
  - mem_rsp_valid in the same cycle as the mem_req_ready handshake is not legal and is not sampled.
- RESP: rsp_valid=1; outputs held until rsp_ready, then → IDLE. req_ready stays 0 here, so there is no back-to-back accept in the response cycle.
- Only one transaction is outstanding; req_ready=0 in REQ/WAIT/RESP.
- Minimum latency with zero-wait memory:
  - accept at T
  - mem handshake at T+1
  - mem_rsp_valid at T+2
  - rsp_valid at T+3
- Error path latency: rsp_valid at T+1.
- mem_rsp_valid outside WAIT is ignored.
- Addresses near the top of the address space: no wrap handling needed, because aligned accesses never cross a word.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (F3_LB..F3_LWU)
  - state enum (IDLE/REQ/WAIT/RESP)
  - function size_bytes(funct3)
  - function is_legal(funct3, we, XLEN)
- One combinational sub-module, lsu_align (parametrised by XLEN):
  - store path: wdata shift and wstrb generation
  - load path: lane extract and sign/zero extend
  - used by lsu_mem_ctrl for both directions

Test Plan:
- Load lb, XLEN=32, addr 0x8000_0003, mem_rdata 0x80FF_1234 → mem_addr 0x8000_0000, mem_wstrb 0, rsp_rdata 0xFFFF_FF80, rsp_err 0.
- Store sh, addr 0x8000_0002, req_wdata 0xDEAD_BEEF → mem_wdata 0xBEEF_0000, mem_wstrb 4'b1100, mem_we 1, response rsp_rdata 0, rsp_err 0.
- Misaligned lw at addr 0x8000_0006 → rsp_valid one cycle after accept, rsp_err 1, mem_req_valid never asserted.
- Backpressure:
  - hold mem_req_ready=0 for 5 cycles → mem_req_valid and its fields stable;
  - hold rsp_ready=0 for 3 cycles → rsp_valid and rsp_rdata stable, req_ready 0 throughout.
- XLEN=64:
  - lwu at addr 0x10, mem_rdata 0x0000_0000_8000_0001 → rsp_rdata 0x0000_0000_8000_0001;
  - ld at 0x18 → full 64-bit data.
- Reset in WAIT: drop rst_n for one cycle, then drive a stale mem_rsp_valid → outputs all 0, no rsp_valid, req_ready 1.

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_pkg: funct3 codes, controller states and access-size helpers for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    // Low two funct3 bits encode log2 of the access size in bytes.
    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

    // Stores have no unsigned variants; doubleword forms exist only on 64-bit cores.
    function automatic logic is_legal(input logic [2:0] f3, input logic we, input int xlen);
        if (we)
            return f3 inside {F3_LB, F3_LH, F3_LW} || (xlen == 64 && f3 == F3_LD);
        return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU} || (xlen == 64 && f3 inside {F3_LD, F3_LWU});
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_req_if / lsu_bus_if: execute-stage request/response channel and aligned memory port
interface lsu_req_if #(parameter int XLEN = 32, parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
                    input  req_ready, rsp_valid, rsp_rdata, rsp_err);
    modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
                    output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

interface lsu_bus_if #(parameter int XLEN = 32, parameter int ADDR_W = 32);
    localparam int STRB_W = XLEN / 8;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rdata;
    modport master (output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
                    input  mem_req_ready, mem_rsp_valid, mem_rdata);
    modport slave  (input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
                    output mem_req_ready, mem_rsp_valid, mem_rdata);
endinterface

// File: rtl/lsu_mem_ctrl_align.sv
// lsu_align: byte-lane placement of store data/strobes and extraction/extension of load data
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int STRB_W = XLEN / 8,
    localparam int OFF_W = $clog2(STRB_W)
) (
    input  logic [2:0]        funct3_i,
    input  logic              we_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [XLEN-1:0]   wdata_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic [XLEN-1:0]   rdata_o
);
    logic [STRB_W-1:0] mask;
    logic [XLEN-1:0]   sh;
    logic [XLEN-1:0]   keep;
    logic              sgn;

    // Size mask drives both directions; sign comes from the top kept bit of the shifted word.
    always_comb begin
        mask = (STRB_W'(1) << size_bytes(funct3_i)) - STRB_W'(1);
        keep = '0;
        for (int i = 0; i < STRB_W; i++) keep[8*i +: 8] = {8{mask[i]}};
        sh = rdata_i >> {off_i, 3'b000};
        sgn = ~funct3_i[2] & |(sh & keep & ~(keep >> 1));
        rdata_o = (sh & keep) | ({XLEN{sgn}} & ~keep);
        wdata_o = wdata_i << {off_i, 3'b000};
        wstrb_o = we_i ? mask << off_i : '0;
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store controller between execute stage and memory port
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ADDR_W = 32,
    localparam int STRB_W = XLEN / 8,
    localparam int OFF_W = $clog2(STRB_W)
) (
    input logic       clk,
    input logic       rst_n,
    lsu_req_if.slave  core,
    lsu_bus_if.master mem
);
    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
    logic              idle, bad;
    logic [XLEN-1:0]   al_wdata, al_rdata;
    logic [STRB_W-1:0] al_wstrb;

    assign idle = state_q == IDLE;
    assign bad  = !is_legal(core.req_funct3, core.req_we, XLEN)
                || |(4'(core.req_addr[OFF_W-1:0]) & (size_bytes(core.req_funct3) - 4'd1));

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3_i (idle ? core.req_funct3 : f3_q),
        .we_i     (core.req_we),
        .off_i    (idle ? core.req_addr[OFF_W-1:0] : off_q),
        .wdata_i  (core.req_wdata),
        .rdata_i  (mem.mem_rdata),
        .wdata_o  (al_wdata),
        .wstrb_o  (al_wstrb),
        .rdata_o  (al_rdata)
    );

    // Next state and registered outputs; handshake outputs follow the state being entered.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        off_d       = off_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        unique case (state_q)
            IDLE: if (core.req_valid && req_ready_q) begin
                we_d        = core.req_we;
                f3_d        = core.req_funct3;
                off_d       = core.req_addr[OFF_W-1:0];
                rsp_err_d   = bad;
                rsp_rdata_d = '0;
                state_d     = bad ? RESP : REQ;
                if (!bad) begin
                    mem_we_d    = core.req_we;
                    mem_addr_d  = {core.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    mem_wdata_d = al_wdata;
                    mem_wstrb_d = al_wstrb;
                end
            end
            REQ:  if (mem.mem_req_ready) state_d = WAIT;
            WAIT: if (mem.mem_rsp_valid) begin
                rsp_rdata_d = we_q ? '0 : al_rdata;
                rsp_err_d   = 1'b0;
                state_d     = RESP;
            end
            RESP: if (core.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_ready_d     = state_d == IDLE;
        rsp_valid_d     = state_d == RESP;
        mem_req_valid_d = state_d == REQ;
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            we_q            <= 1'b0;
            f3_q            <= '0;
            off_q           <= '0;
            req_ready_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_err_q       <= 1'b0;
            rsp_rdata_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wstrb_q     <= '0;
        end else begin
            state_q         <= state_d;
            we_q            <= we_d;
            f3_q            <= f3_d;
            off_q           <= off_d;
            req_ready_q     <= req_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_err_q       <= rsp_err_d;
            rsp_rdata_q     <= rsp_rdata_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wstrb_q     <= mem_wstrb_d;
        end
    end

    assign core.req_ready    = req_ready_q;
    assign core.rsp_valid    = rsp_valid_q;
    assign core.rsp_err      = rsp_err_q;
    assign core.rsp_rdata    = rsp_rdata_q;
    assign mem.mem_req_valid = mem_req_valid_q;
    assign mem.mem_we        = mem_we_q;
    assign mem.mem_addr      = mem_addr_q;
    assign mem.mem_wdata     = mem_wdata_q;
    assign mem.mem_wstrb     = mem_wstrb_q;
endmodule
